// File: rtl/tcdm_responder.sv
// Banked word-interleaved TCDM slave memory for NB_PORTS masters, per-bank round-robin arbitration.
// Latency: gnt_o combinational in the request cycle; r_valid_o/r_data_o registered one cycle after grant.
// Backpressure: losing masters hold their request until granted; responses cannot be stalled. Optional random stall: TCDM_RESP_STALL_EN.
module tcdm_responder #(
    parameter int unsigned NB_PORTS   = 3,
    parameter int unsigned NB_BANKS   = 4,
    parameter int unsigned BANK_WORDS = 256,
    parameter logic [31:0] BASE_ADDR  = 32'h0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NB_PORTS-1:0]    req_i,
    output logic [NB_PORTS-1:0]    gnt_o,
    input  logic [NB_PORTS*32-1:0] add_i,
    input  logic [NB_PORTS-1:0]    wen_i,
    input  logic [NB_PORTS*4-1:0]  be_i,
    input  logic [NB_PORTS*32-1:0] data_i,
    output logic [NB_PORTS*32-1:0] r_data_o,
    output logic [NB_PORTS-1:0]    r_valid_o
);
    localparam int unsigned BANK_BITS = (NB_BANKS > 1) ? $clog2(NB_BANKS) : 1;
    localparam int unsigned ROW_BITS  = (BANK_WORDS > 1) ? $clog2(BANK_WORDS) : 1;
    localparam int unsigned PORT_BITS = (NB_PORTS > 1) ? $clog2(NB_PORTS) : 1;

    logic [31:0]          mem_q [NB_BANKS][BANK_WORDS];
    logic [BANK_BITS-1:0] bank_of [NB_PORTS];
    logic [ROW_BITS-1:0]  row_of  [NB_PORTS];
    logic [PORT_BITS-1:0] rr_q [NB_BANKS];
    logic [PORT_BITS-1:0] rr_d [NB_BANKS];
    logic [PORT_BITS-1:0] win  [NB_BANKS];
    logic [NB_BANKS-1:0]  bank_req;
    logic [NB_BANKS-1:0]  bank_gnt;
    logic [NB_BANKS-1:0]  stall;
    logic [NB_PORTS-1:0]         r_valid_q, r_valid_d;
    logic [NB_PORTS-1:0][31:0]   r_data_q, r_data_d;
`ifdef TCDM_RESP_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;
`endif

    // Address decode: word index relative to BASE_ADDR, low bits pick the bank, next bits the row
    always_comb begin
        for (int unsigned p = 0; p < NB_PORTS; p++) begin
            logic [31:0] word;
            word       = (add_i[p*32 +: 32] - BASE_ADDR) >> 2;
            bank_of[p] = BANK_BITS'(word % NB_BANKS);
            row_of[p]  = ROW_BITS'((word / NB_BANKS) % BANK_WORDS);
        end
    end

    // Per-bank round-robin search starting at rr_q[b]; first matching requester wins
    always_comb begin
        int unsigned cand;
        cand     = 0;
        bank_req = '0;
        for (int unsigned b = 0; b < NB_BANKS; b++) begin
            win[b] = '0;
            for (int unsigned i = 0; i < NB_PORTS; i++) begin
                cand = 32'(rr_q[b]) + i;
                if (cand >= NB_PORTS) cand = cand - NB_PORTS;
                if (!bank_req[b] && req_i[cand] && (bank_of[cand] == BANK_BITS'(b))) begin
                    bank_req[b] = 1'b1;
                    win[b]      = PORT_BITS'(cand);
                end
            end
        end
    end

    // Stall mask: random bank stalls when enabled, otherwise none
    always_comb begin
        stall = '0;
`ifdef TCDM_RESP_STALL_EN
        for (int unsigned b = 0; b < NB_BANKS; b++) begin
            stall[b] = lfsr_q[b % 16] & lfsr_q[(b + 4) % 16];
        end
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
`endif
    end

    // Final grants, pointer advance and response next-state
    always_comb begin
        bank_gnt  = bank_req & ~stall & {NB_BANKS{~rst_i}};
        gnt_o     = '0;
        r_data_d  = r_data_q;
        for (int unsigned b = 0; b < NB_BANKS; b++) begin
            rr_d[b] = rr_q[b];
            if (bank_gnt[b]) begin
                gnt_o[win[b]] = 1'b1;
                rr_d[b] = (32'(win[b]) + 1 >= NB_PORTS) ? '0 : PORT_BITS'(win[b] + 1'b1);
            end
        end
        r_valid_d = gnt_o & req_i;
        for (int unsigned p = 0; p < NB_PORTS; p++) begin
            if (gnt_o[p] && wen_i[p]) r_data_d[p] = mem_q[bank_of[p]][row_of[p]];
        end
    end

    // Control and response registers, synchronously reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid_q <= '0;
            r_data_q  <= '0;
            for (int unsigned b = 0; b < NB_BANKS; b++) rr_q[b] <= '0;
`ifdef TCDM_RESP_STALL_EN
            lfsr_q    <= 16'hACE1;
`endif
        end else begin
            r_valid_q <= r_valid_d;
            r_data_q  <= r_data_d;
            for (int unsigned b = 0; b < NB_BANKS; b++) rr_q[b] <= rr_d[b];
`ifdef TCDM_RESP_STALL_EN
            lfsr_q    <= lfsr_d;
`endif
        end
    end

    // Byte-enabled writes from each bank's winner; storage is never reset
    always_ff @(posedge clk_i) begin
        for (int unsigned b = 0; b < NB_BANKS; b++) begin
            if (bank_gnt[b] && !wen_i[win[b]]) begin
                for (int unsigned k = 0; k < 4; k++) begin
                    if (be_i[32'(win[b]) * 4 + k])
                        mem_q[b][row_of[win[b]]][k*8 +: 8] <= data_i[32'(win[b]) * 32 + k * 8 +: 8];
                end
            end
        end
    end

    assign r_valid_o = r_valid_q;
    assign r_data_o  = r_data_q;

endmodule

// File: tb/tb_tcdm_responder.sv
// Bench for tcdm_responder: directed vector table, hand sequences, randomized traffic vs memory model.
// Latency checked: grant in request cycle, response one cycle later.
// Backpressure: modelled masters hold requests until granted.
module tb_tcdm_responder;
    localparam int NP = 3;
    localparam int NB = 4;
    localparam int BW = 256;

    logic clk = 1'b0;
    logic rst;
    logic [NP-1:0] req, gnt, wen, r_valid;
    logic [NP*32-1:0] add, data, r_data;
    logic [NP*4-1:0] be;
    logic [31:0] p_add [NP];
    logic [31:0] p_dat [NP];
    logic [3:0]  p_be  [NP];

    always #5 clk = ~clk;

    always_comb begin
        for (int p = 0; p < NP; p++) begin
            add[p*32 +: 32]  = p_add[p];
            data[p*32 +: 32] = p_dat[p];
            be[p*4 +: 4]     = p_be[p];
        end
    end

    tcdm_responder #(.NB_PORTS(NP), .NB_BANKS(NB), .BANK_WORDS(BW), .BASE_ADDR(32'h0)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt), .add_i(add), .wen_i(wen),
        .be_i(be), .data_i(data), .r_data_o(r_data), .r_valid_o(r_valid)
    );

    int total_cnt = 0;
    int pass_cnt  = 0;

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else pass_cnt++;
    endtask

    task automatic chkm(input string nm, input logic [31:0] act, input logic [31:0] exp, input logic [31:0] m);
        total_cnt++;
        if (((act ^ exp) & m) !== 32'h0) $display("FAIL %s: got %h expected %h mask %h", nm, act, exp, m);
        else pass_cnt++;
    endtask

    task automatic idle();
        req = '0; wen = '1;
        for (int p = 0; p < NP; p++) begin p_add[p] = '0; p_dat[p] = '0; p_be[p] = '0; end
    endtask

    task automatic do_reset();
        rst = 1'b1; idle();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    typedef struct {
        logic [NP-1:0]        req, wen, exp_gnt, chk_rd;
        logic [NP-1:0][31:0]  add, dat, exp_rd;
        logic [NP-1:0][3:0]   be;
    } vec_t;
    vec_t vecs[10];

    task automatic vp(input int i, input int p, input logic [31:0] a, input logic w,
                      input logic [3:0] b, input logic [31:0] d);
        vecs[i].req[p] = 1'b1; vecs[i].add[p] = a; vecs[i].wen[p] = w;
        vecs[i].be[p] = b; vecs[i].dat[p] = d;
    endtask

    task automatic ve(input int i, input logic [NP-1:0] g, input logic [NP-1:0] c,
                      input logic [31:0] r0, input logic [31:0] r1, input logic [31:0] r2);
        vecs[i].exp_gnt = g; vecs[i].chk_rd = c;
        vecs[i].exp_rd[0] = r0; vecs[i].exp_rd[1] = r1; vecs[i].exp_rd[2] = r2;
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % (NB * BW));
    endfunction

    // Behavioural model state for the randomized phase
    logic [31:0] m_mem [NB*BW];
    logic [3:0]  m_known [NB*BW];
    int          rr_m [NB];
    logic [NP-1:0] t_v, pg, gprev;
    logic [31:0] t_add [NP];
    logic [31:0] t_dat [NP];
    logic [3:0]  t_be [NP];
    logic        t_wen [NP];
    logic [31:0] exp_rd [NP];
    logic [31:0] rd_mask [NP];

    function automatic logic [31:0] be_mask(input logic [3:0] k);
        return {{8{k[3]}}, {8{k[2]}}, {8{k[1]}}, {8{k[0]}}};
    endfunction

    initial begin
        int nreq, issued, done, limit;
        rst = 1'b1; idle();
        // Reset state: requests present during reset must not be granted
        req = 3'b111; wen = 3'b111;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_gnt", 96'(gnt), 96'(3'b000));
        chk("reset_rvalid", 96'(r_valid), 96'(3'b000));
        chk("reset_rdata", r_data, 96'h0);
        idle();
        @(posedge clk);
        #1 rst = 1'b0;

`ifndef TCDM_RESP_STALL_EN
        for (int i = 0; i < 10; i++) vecs[i] = '{default: '0};
        vp(0, 0, 32'h10, 1'b0, 4'hF, 32'hDEADBEEF); ve(0, 3'b001, 3'b000, 0, 0, 0);
        vp(1, 0, 32'h10, 1'b1, 4'h0, 32'h0);        ve(1, 3'b001, 3'b001, 32'hDEADBEEF, 0, 0);
        vp(2, 1, 32'h10, 1'b0, 4'h2, 32'h0000AA00); ve(2, 3'b010, 3'b000, 0, 0, 0);
        vp(3, 2, 32'h10, 1'b1, 4'h0, 32'h0);        ve(3, 3'b100, 3'b100, 0, 0, 32'hDEADAAEF);
        vp(4, 0, 32'h0, 1'b0, 4'hF, 32'h11111111);
        vp(4, 1, 32'h4, 1'b0, 4'hF, 32'h22222222);
        vp(4, 2, 32'h8, 1'b0, 4'hF, 32'h33333333);  ve(4, 3'b111, 3'b101, 32'hDEADBEEF, 0, 32'hDEADAAEF);
        vp(5, 0, 32'h0, 1'b1, 4'h0, 0);
        vp(5, 1, 32'h4, 1'b1, 4'h0, 0);
        vp(5, 2, 32'h8, 1'b1, 4'h0, 0);             ve(5, 3'b111, 3'b111, 32'h11111111, 32'h22222222, 32'h33333333);
        vp(6, 1, 32'h1000, 1'b0, 4'hF, 32'h55);     ve(6, 3'b010, 3'b010, 0, 32'h22222222, 0);
        vp(7, 0, 32'h0, 1'b1, 4'h0, 0);
        vp(7, 2, 32'h8, 1'b0, 4'h0, 32'hFFFFFFFF);  ve(7, 3'b101, 3'b101, 32'h55, 0, 32'h33333333);
        vp(8, 0, 32'h9, 1'b1, 4'h0, 0);             ve(8, 3'b001, 3'b001, 32'h33333333, 0, 0);
        vp(9, 2, 32'h20, 1'b0, 4'hF, 32'hCAFEF00D); ve(9, 3'b100, 3'b000, 0, 0, 0);

        for (int i = 0; i < 10; i++) begin
            req = vecs[i].req; wen = vecs[i].wen;
            for (int p = 0; p < NP; p++) begin
                p_add[p] = vecs[i].add[p]; p_dat[p] = vecs[i].dat[p]; p_be[p] = vecs[i].be[p];
            end
            #1 chk($sformatf("vec%0d_gnt", i), 96'(gnt), 96'(vecs[i].exp_gnt));
            @(posedge clk);
            #1 idle();
            chk($sformatf("vec%0d_rvalid", i), 96'(r_valid), 96'(vecs[i].exp_gnt));
            for (int p = 0; p < NP; p++)
                if (vecs[i].chk_rd[p])
                    chk($sformatf("vec%0d_rdata%0d", i, p), 96'(r_data[p*32 +: 32]), 96'(vecs[i].exp_rd[p]));
        end

        // Three ports contend for bank 0 right after reset: served 0, 1, 2 in turn
        do_reset();
        req = 3'b111; wen = 3'b111;
        p_add[0] = 32'h0; p_add[1] = 32'h10; p_add[2] = 32'h20;
        exp_rd[0] = 32'h55; exp_rd[1] = 32'hDEADAAEF; exp_rd[2] = 32'hCAFEF00D;
        for (int k = 0; k < 3; k++) begin
            #1 chk($sformatf("rr_gnt%0d", k), 96'(gnt), 96'(3'b001 << k));
            @(posedge clk);
            #1 req[k] = 1'b0;
            chk($sformatf("rr_rvalid%0d", k), 96'(r_valid), 96'(3'b001 << k));
            chk($sformatf("rr_rdata%0d", k), 96'(r_data[k*32 +: 32]), 96'(exp_rd[k]));
        end
        @(posedge clk);
        #1 chk("rr_rvalid_idle", 96'(r_valid), 96'(3'b000));

        // Reset arriving while a read is pending drops the response, memory survives
        req = 3'b001; wen = 3'b001; p_add[0] = 32'h10;
        #1 chk("rst_mid_gnt", 96'(gnt), 96'(3'b001));
        rst = 1'b1;
        #1 chk("rst_mid_gnt_forced", 96'(gnt), 96'(3'b000));
        @(posedge clk);
        #1 chk("rst_mid_rvalid", 96'(r_valid), 96'(3'b000));
        chk("rst_mid_rdata", r_data, 96'h0);
        rst = 1'b0;
        #1 chk("rst_after_gnt", 96'(gnt), 96'(3'b001));
        @(posedge clk);
        #1 idle();
        chk("rst_after_rvalid", 96'(r_valid), 96'(3'b001));
        chk("rst_retained", 96'(r_data[31:0]), 96'(32'hDEADAAEF));
        nreq = 600;
`else
        nreq = 1000;
`endif

        // Randomized traffic against a word-level memory model
        do_reset();
        for (int i = 0; i < NB*BW; i++) begin m_mem[i] = '0; m_known[i] = '0; end
        for (int b = 0; b < NB; b++) rr_m[b] = 0;
        for (int p = 0; p < NP; p++) begin exp_rd[p] = '0; rd_mask[p] = '1; end
        t_v = '0; issued = 0; done = 0; limit = nreq * 6 + 100;
        for (int cyc = 0; cyc < limit && (issued < nreq || t_v != '0); cyc++) begin
            for (int p = 0; p < NP; p++) begin
                if (!t_v[p] && issued < nreq && $urandom_range(0, 9) < 7) begin
                    t_v[p]   = 1'b1;
                    t_add[p] = (32'($urandom_range(0, 15)) + 32'(NB*BW) * 32'($urandom_range(0, 3))) * 4
                               + 32'($urandom_range(0, 3));
                    t_wen[p] = 1'($urandom_range(0, 1));
                    t_be[p]  = 4'($urandom_range(0, 15));
                    t_dat[p] = $urandom;
                    issued++;
                end
                p_add[p] = t_add[p]; p_dat[p] = t_dat[p]; p_be[p] = t_be[p]; wen[p] = t_wen[p];
            end
            req = t_v;
            #1;
`ifndef TCDM_RESP_STALL_EN
            pg = '0;
            for (int b = 0; b < NB; b++) begin
                for (int i = 0; i < NP; i++) begin
                    int p;
                    p = (rr_m[b] + i) % NP;
                    if (pg == (pg & ~(3'b111)) || 1) begin
                        if (t_v[p] && (widx(t_add[p]) % NB) == b && rr_m[b] >= 0) begin
                            pg[p] = 1'b1; rr_m[b] = (p + 1) % NP; break;
                        end
                    end
                end
            end
            chk("rand_gnt", 96'(gnt), 96'(pg));
`else
            begin
                logic ok;
                ok = ((gnt & ~t_v) == '0);
                for (int b = 0; b < NB; b++) begin
                    int n;
                    n = 0;
                    for (int p = 0; p < NP; p++) if (gnt[p] && (widx(t_add[p]) % NB) == b) n++;
                    if (n > 1) ok = 1'b0;
                end
                chk("rand_gnt_legal", 96'(ok), 96'(1'b1));
            end
`endif
            gprev = gnt & t_v;
            for (int p = 0; p < NP; p++) begin
                if (gprev[p] && t_wen[p]) begin
                    exp_rd[p]  = m_mem[widx(t_add[p])];
                    rd_mask[p] = be_mask(m_known[widx(t_add[p])]);
                end
            end
            for (int p = 0; p < NP; p++) begin
                if (gprev[p] && !t_wen[p]) begin
                    m_mem[widx(t_add[p])] = (m_mem[widx(t_add[p])] & ~be_mask(t_be[p]))
                                            | (t_dat[p] & be_mask(t_be[p]));
                    m_known[widx(t_add[p])] = m_known[widx(t_add[p])] | t_be[p];
                end
                if (gprev[p]) begin t_v[p] = 1'b0; done++; end
            end
            @(posedge clk);
            #1;
            chk("rand_rvalid", 96'(r_valid), 96'(gprev));
            for (int p = 0; p < NP; p++)
                chkm($sformatf("rand_rdata%0d", p), r_data[p*32 +: 32], exp_rd[p], rd_mask[p]);
        end
        idle();
        chk("rand_all_done", 96'(done), 96'(nreq));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
